// File: rtl/exe_defs.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op encodings,
// FSM state encoding and operand signedness helpers.
package exe_defs;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StMul  = 3'd1,
      StDiv  = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } state_e;

   function automatic logic a_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/exe_div_iter.sv
// One restoring divide step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module exe_div_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {1'b0, divisor_i};
      // Top bit of diff is the borrow: set only when the divisor does not fit.
      if (!diff[XLEN]) begin
         rem_o = diff[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready request and result
// handshakes, shift-add multiplier, restoring divider and flush abort.
module exe_muldiv
   import exe_defs::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RD_W    = 11,
   parameter int unsigned MUL_BPC = 1
) (
   input  logic            clk,
   input  logic            rstl,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [RD_W-1:0] rd_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic [RD_W-1:0] rd_o,
   output logic            div_by_zero_o,
   output logic            busy_o
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;
   localparam int unsigned MUL_N = XLEN / MUL_BPC;
   localparam logic [CNT_W-1:0]    MUL_LAST = CNT_W'(MUL_N - 1);
   localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [XLEN-1:0]     ONE_X    = XLEN'(1);
   localparam logic [2*XLEN-1:0]   ONE_2X   = (2 * XLEN)'(1);
   localparam logic [XLEN-1:0]     MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [RD_W-1:0]     rd_q, rd_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                dbz_q, dbz_d;

   logic                sa, sb;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                rs2_zero, ovf;
   logic [XLEN+MUL_BPC-1:0] pp, hi_sum;
   logic [2*XLEN-1:0]   mul_next, prod;
   logic [XLEN-1:0]     div_rem, div_quo, div_val, fix_result;

   exe_div_iter #(
      .XLEN (XLEN)
   ) u_div_iter (
      .rem_i     (acc_q[2*XLEN-1:XLEN]),
      .quo_i     (acc_q[XLEN-1:0]),
      .divisor_i (opb_q),
      .rem_o     (div_rem),
      .quo_o     (div_quo)
   );

   always_comb begin
      sa       = a_signed(op_i) & rs1_i[XLEN-1];
      sb       = b_signed(op_i) & rs2_i[XLEN-1];
      a_mag    = sa ? (~rs1_i + ONE_X) : rs1_i;
      b_mag    = sb ? (~rs2_i + ONE_X) : rs2_i;
      rs2_zero = (rs2_i == '0);
      ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == MIN_X) && (&rs2_i);
   end

   // Multiplier bits sit in the low half of acc_q and shift out as the
   // product accumulates into the high half.
   always_comb begin
      pp = '0;
      for (int j = 0; j < MUL_BPC; j++) begin
         if (acc_q[j]) pp = pp + ({{MUL_BPC{1'b0}}, opb_q} << j);
      end
      hi_sum   = {{MUL_BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
      mul_next = {hi_sum, acc_q[XLEN-1:MUL_BPC]};
   end

   always_comb begin
      prod    = neg_q ? (~acc_q + ONE_2X) : acc_q;
      div_val = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      if (!op_q[2]) fix_result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else          fix_result = neg_q ? (~div_val + ONE_X) : div_val;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      if (flush_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  op_d  = op_i;
                  rd_d  = rd_i;
                  cnt_d = '0;
                  dbz_d = 1'b0;
                  neg_d = (op_i[2] && op_i[1]) ? sa : (sa ^ sb);
                  if (op_i[2] && rs2_zero) begin
                     result_d = op_i[1] ? rs1_i : '1;
                     dbz_d    = 1'b1;
                     state_d  = StDone;
                  end else if (ovf) begin
                     result_d = op_i[1] ? '0 : rs1_i;
                     state_d  = StDone;
                  end else if (op_i[2]) begin
                     acc_d   = {{XLEN{1'b0}}, a_mag};
                     opb_d   = b_mag;
                     state_d = StDiv;
                  end else begin
                     acc_d   = {{XLEN{1'b0}}, b_mag};
                     opb_d   = a_mag;
                     state_d = StMul;
                  end
               end
            end
            StMul: begin
               acc_d = mul_next;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == MUL_LAST) begin
                  cnt_d   = '0;
                  state_d = StFix;
               end
            end
            StDiv: begin
               acc_d = {div_rem, div_quo};
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == DIV_LAST) begin
                  cnt_d   = '0;
                  state_d = StFix;
               end
            end
            StFix: begin
               result_d = fix_result;
               state_d  = StDone;
            end
            StDone: begin
               if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rstl) begin
         state_q  <= StIdle;
         op_q     <= '0;
         rd_q     <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   assign in_ready_o    = (state_q == StIdle) && !flush_i;
   assign out_valid_o   = (state_q == StDone);
   assign busy_o        = (state_q != StIdle);
   assign result_o      = result_q;
   assign rd_o          = rd_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed self-checking bench for exe_muldiv: latency, results, fast paths,
// back-pressure, flush and mid-operation reset.
module tb_exe_muldiv;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic        clk = 1'b0;
   logic        rstl = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic [10:0] rd_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic [10:0] rd_out;
   logic        dbz;
   logic        busy;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   exe_muldiv #(
      .XLEN    (32),
      .RD_W    (11),
      .MUL_BPC (1)
   ) dut (
      .clk           (clk),
      .rstl          (rstl),
      .flush_i       (flush),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .op_i          (op),
      .rs1_i         (rs1),
      .rs2_i         (rs2),
      .rd_i          (rd_in),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .result_o      (result),
      .rd_o          (rd_out),
      .div_by_zero_o (dbz),
      .busy_o        (busy)
   );

   // Presents one request; returns just after the c0 edge (inside c1).
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [10:0] r);
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      rs1 = a;
      rs2 = b;
      rd_in = r;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Returns the cycle index cK of the first out_valid, or -1 after 200 cycles.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [10:0] r, output logic [31:0] res,
                         output logic [10:0] rdo, output logic z, output int lat);
      issue(o, a, b, r);
      wait_valid(lat);
      res = result;
      rdo = rd_out;
      z = dbz;
      if (lat > 0) out_ready = 1'b1;
      else flush = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 rstl = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, busy, dbz} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, busy, dbz});
      end
      n_cmp++;
      if (result !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_result: got %h want 00000000", result);
      end
      n_cmp++;
      if (rd_out !== 11'h0) begin
         n_fail++;
         $display("FAIL reset_rd: got %h want 000", rd_out);
      end
   endtask

   task automatic test_mul();
      logic [31:0] res;
      logic [10:0] rdo;
      logic z;
      int lat;
      run_op(MUL, 32'd7, 32'hFFFF_FFFD, 11'h5A5, res, rdo, z, lat);
      n_cmp++;
      if (lat !== 34) begin
         n_fail++;
         $display("FAIL mul_latency: got c%0d want c34", lat);
      end
      n_cmp++;
      if (res !== 32'hFFFF_FFEB) begin
         n_fail++;
         $display("FAIL mul_result: got %h want ffffffeb", res);
      end
      n_cmp++;
      if (rdo !== 11'h5A5) begin
         n_fail++;
         $display("FAIL mul_rd: got %h want 5a5", rdo);
      end
      n_cmp++;
      if (z !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_dbz: got %b want 0", z);
      end
   endtask

   task automatic test_mulh();
      logic [2:0]  ops [3];
      logic [31:0] exp [3];
      logic [31:0] res;
      logic [10:0] rdo;
      logic z;
      int lat;
      ops = '{MULHU, MULH, MULHSU};
      exp = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 11'(i + 1), res, rdo, z, lat);
         n_cmp++;
         if (res !== exp[i] || lat !== 34) begin
            n_fail++;
            $display("FAIL mulh_%0d: got %h at c%0d want %h at c34", i, res, lat, exp[i]);
         end
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops [4];
      logic [31:0] av [4];
      logic [31:0] bv [4];
      logic [31:0] exp [4];
      logic [31:0] res;
      logic [10:0] rdo;
      logic z;
      int lat;
      ops = '{DIV, REM, DIVU, REMU};
      av  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      bv  = '{32'd2, 32'd2, 32'd7, 32'd7};
      exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], av[i], bv[i], 11'h40, res, rdo, z, lat);
         n_cmp++;
         if (res !== exp[i] || lat !== 34 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL div_%0d: got %h c%0d dbz=%b want %h c34 dbz=0",
                     i, res, lat, z, exp[i]);
         end
      end
   endtask

   task automatic test_fast_path();
      logic [2:0]  ops [4];
      logic [31:0] av [4];
      logic [31:0] bv [4];
      logic [31:0] exp [4];
      logic        expz [4];
      logic [31:0] res;
      logic [10:0] rdo;
      logic z;
      int lat;
      ops  = '{DIVU, REM, DIV, REM};
      av   = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
      bv   = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      exp  = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
      expz = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], av[i], bv[i], 11'h77, res, rdo, z, lat);
         n_cmp++;
         if (res !== exp[i] || lat !== 1 || z !== expz[i] || rdo !== 11'h77) begin
            n_fail++;
            $display("FAIL fast_%0d: got %h c%0d dbz=%b rd=%h want %h c1 dbz=%b rd=077",
                     i, res, lat, z, rdo, exp[i], expz[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      issue(DIVU, 32'd100, 32'd7, 11'h003);
      wait_valid(lat);
      n_cmp++;
      if (lat !== 34) begin
         n_fail++;
         $display("FAIL bp_latency: got c%0d want c34", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (result !== 32'd14 || rd_out !== 11'h003 || {out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got %h rd=%h v/r=%b want 0000000e rd=003 v/r=10",
                     i, result, rd_out, {out_valid, in_ready});
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_release: got v/r=%b want 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      logic [10:0] rdo;
      logic z;
      int lat;
      logic seen;
      issue(DIV, 32'd1000, 32'd3, 11'h007);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      op = MUL;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready_busy: got %b want 0", in_ready);
      end
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, in_ready, out_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL flush_abort: got b/r/v=%b want 010", {busy, in_ready, out_valid});
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_no_valid: got %b want 0", seen);
      end
      // A request offered while idle and flushing must be dropped.
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready_idle: got %b want 0", in_ready);
      end
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop: got busy=%b want 0", busy);
      end
      run_op(MUL, 32'd3, 32'd4, 11'h012, res, rdo, z, lat);
      n_cmp++;
      if (res !== 32'd12 || lat !== 34 || rdo !== 11'h012) begin
         n_fail++;
         $display("FAIL flush_then_mul: got %h c%0d rd=%h want 0000000c c34 rd=012",
                  res, lat, rdo);
      end
   endtask

   task automatic test_reset_midop();
      logic seen;
      issue(MUL, 32'd5, 32'd6, 11'h155);
      repeat (5) @(negedge clk);
      rstl = 1'b1;
      @(posedge clk);
      #1 rstl = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, busy, dbz} !== 4'b1000 || result !== 32'h0 || rd_out !== 11'h0)
      begin
         n_fail++;
         $display("FAIL reset_midop: got r/v/b/z=%b res=%h rd=%h want 1000 00000000 000",
                  {in_ready, out_valid, busy, dbz}, result, rd_out);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_valid: got %b want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_fast_path();
      test_backpressure();
      test_flush();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
